ram_bus_responder: RTL and testbench
====================================

# ram_bus_responder

Memory-side responder for the CPU RAM bus: the CPU drives the address, read/write strobe and write data; this block returns read data and commits writes. It holds a parameterised single-port word RAM, clears it after reset with a sweep state machine, and maps a small I/O window (LED output register, cycle counter, write counter) at the top of the 16-bit address space. It sits between the CPU core and the board pins, replacing the vendor RAM megafunction in the top level.

## Interface

- ADDR_BITS, 10, RAM depth is 2^ADDR_BITS 16-bit words (DEPTH); must be ≤ 15
- IO_BASE, 16'hFF00, base address of the I/O window; must be ≥ DEPTH

- wire_clock  in  1  single clock; all state changes on its rising edge
- wire_reset_n  in  1  synchronous, active-low reset
- bus_RAM_ADDRESS  in  16  word address from CPU
- wire_RW  in  1  1 = write, 0 = read
- bus_RAM_DATA_IN  in  16  write data from CPU
- bus_RAM_DATA_OUT  out  16  read data to CPU (combinational from address and registered state)
- wire_ready  out  1  1 once the post-reset clear sweep has finished
- bus_LED  out  16  memory-mapped output register

## Operation

- States: CLEAR, RUN. Reset (wire_reset_n=0 at an edge) forces CLEAR, clear_addr=0, bus_LED=0, cycle_cnt=0, write_cnt=0, wire_ready=0.
- CLEAR: each edge writes 0 to mem[clear_addr], clear_addr++. On the edge that clears DEPTH-1, go to RUN and set wire_ready=1. CPU writes ignored; bus_RAM_DATA_OUT=0.
- RUN: stays until reset. No other transitions.
- Address decode (RUN):
  - addr < DEPTH: RAM word.
  - DEPTH ≤ addr < IO_BASE: unmapped; reads 0, writes dropped.
  - IO_BASE+0: bus_LED, read/write.
  - IO_BASE+1: cycle_cnt, read-only.
  - IO_BASE+2: write_cnt, read-only.
  - other IO_BASE+n: reads 0, writes dropped.
- Read: bus_RAM_DATA_OUT = decoded value for the current bus_RAM_ADDRESS, no clock needed (asynchronous array read). Required because the CPU presents an address on one edge and samples data on the next.
- Write: level-sensitive. Every edge in RUN with wire_RW=1 commits bus_RAM_DATA_IN to the decoded target. RW held high for k edges gives k writes.
- cycle_cnt: +1 on every edge with wire_reset_n=1, in both states; 16-bit, wraps FFFF→0000.
- write_cnt: +1 per committed RAM write (addr < DEPTH only); saturates at FFFF. LED writes and dropped writes do not count.

## Timing

- Read latency 0 cycles: the output follows the address combinationally. Data is stable before the CPU's next sampling edge.
- Write latency 1 edge: a read of the same address shows the old value until the committing edge, and the new value after it. No bypass.
- Clear sweep: wire_ready rises after exactly DEPTH edges following the first edge with wire_reset_n=1 (1024 for the default).
- Reset mid-sweep or mid-RUN takes effect at that edge and restarts the sweep from word 0. RAM contents not yet re-swept are unspecified but never visible, because reads return 0 during CLEAR.
- Simultaneous write and read to different addresses in one cycle is impossible: one address bus.
- Reset values: bus_RAM_DATA_OUT=0, wire_ready=0, bus_LED=0.

## Test plan

- Reset sweep: hold wire_reset_n=0 for 3 edges, then release with ADDRESS=0, RW=1, DATA_IN=16'hBEEF. Required: wire_ready=0 and DATA_OUT=0 for 1023 edges; wire_ready=1 after edge 1024; mem[0] reads 0000 (write ignored during CLEAR).
- RAM round trip: in RUN, write 16'h1234 to 16'h0005 for one edge, then read 16'h0005. Required: 1234; write_cnt (FF02) = 1; bus_LED unchanged.
- Write-before-edge: after writing AAAA to 16'h0010, drive DATA_IN=5555 with RW=1. Required: DATA_OUT shows AAAA before the edge and 5555 after it.
- I/O window: write 00FF to FF00. Required: bus_LED=00FF on the next edge. Writing to FF01 leaves cycle_cnt counting; reading 0400, FF03 and 8000 returns 0; write_cnt unchanged.
- Counters: 65536 edges after reset release, cycle_cnt reads back its start value (wraps). Performing 65540 RAM writes leaves write_cnt=FFFF.
- Reset mid-RUN: with bus_LED=00FF and mem[5]=1234, pulse reset for 1 edge. Required: bus_LED=0 and wire_ready=0 immediately; after 1024 edges, mem[5] reads 0000.

Source files
------------

// File: rtl/ram_bus_responder.sv
// CPU RAM-bus responder: word RAM with a post-reset clear sweep and an I/O window
// (LED register, cycle counter, write counter) at the top of the address space.
module ram_bus_responder #(
  parameter int unsigned ADDR_BITS = 10,
  parameter logic [15:0] IO_BASE   = 16'hFF00
) (
  input  logic        wire_clock,
  input  logic        wire_reset_n,
  input  logic [15:0] bus_RAM_ADDRESS,
  input  logic        wire_RW,
  input  logic [15:0] bus_RAM_DATA_IN,
  output logic [15:0] bus_RAM_DATA_OUT,
  output logic        wire_ready,
  output logic [15:0] bus_LED
);

  localparam int unsigned Depth  = 2 ** ADDR_BITS;
  localparam logic [15:0] DepthW = 16'(Depth);

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_BITS-1:0]   clear_addr_q, clear_addr_d;
  logic [15:0]            led_q, cycle_cnt_q, write_cnt_q;
  logic [15:0]            mem [Depth];

  logic                   ram_hit, led_hit, cyc_hit, wcnt_hit;
  logic                   wr_en, ram_we;
  logic [ADDR_BITS-1:0]   ram_idx;

  always_comb begin
    ram_hit  = bus_RAM_ADDRESS < DepthW;
    led_hit  = bus_RAM_ADDRESS == IO_BASE;
    cyc_hit  = bus_RAM_ADDRESS == (IO_BASE + 16'd1);
    wcnt_hit = bus_RAM_ADDRESS == (IO_BASE + 16'd2);
    ram_idx  = bus_RAM_ADDRESS[ADDR_BITS-1:0];
    wr_en    = (state_q == StRun) && wire_RW;
    ram_we   = wr_en && ram_hit;
  end

  always_comb begin
    state_d      = state_q;
    clear_addr_d = clear_addr_q;
    if (state_q == StClear) begin
      clear_addr_d = clear_addr_q + ADDR_BITS'(1);
      if (clear_addr_q == '1) state_d = StRun;
    end
  end

  always_ff @(posedge wire_clock) begin
    if (!wire_reset_n) begin
      state_q      <= StClear;
      clear_addr_q <= '0;
      led_q        <= '0;
      cycle_cnt_q  <= '0;
      write_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      clear_addr_q <= clear_addr_d;
      cycle_cnt_q  <= cycle_cnt_q + 16'd1;
      if (wr_en && led_hit) led_q <= bus_RAM_DATA_IN;
      // Saturating count of committed RAM writes only.
      if (ram_we && (write_cnt_q != 16'hFFFF)) write_cnt_q <= write_cnt_q + 16'd1;
    end
  end

  // Array has no reset; the sweep clears it and reads are masked until it ends.
  always_ff @(posedge wire_clock) begin
    if (wire_reset_n) begin
      if (state_q == StClear) begin
        mem[clear_addr_q] <= '0;
      end else if (ram_we) begin
        mem[ram_idx] <= bus_RAM_DATA_IN;
      end
    end
  end

  always_comb begin
    bus_RAM_DATA_OUT = '0;
    if (state_q == StRun) begin
      if (ram_hit)       bus_RAM_DATA_OUT = mem[ram_idx];
      else if (led_hit)  bus_RAM_DATA_OUT = led_q;
      else if (cyc_hit)  bus_RAM_DATA_OUT = cycle_cnt_q;
      else if (wcnt_hit) bus_RAM_DATA_OUT = write_cnt_q;
    end
  end

  assign wire_ready = (state_q == StRun);
  assign bus_LED    = led_q;

endmodule

// File: tb/tb_ram_bus_responder.sv
// Directed bench for ram_bus_responder: vector table plus hand-written sweep,
// counter-wrap/saturation and reset-mid-run sequences.
module tb_ram_bus_responder;

  logic        clk;
  logic        reset_n;
  logic [15:0] addr;
  logic        rw;
  logic [15:0] din;
  logic [15:0] dout;
  logic        ready;
  logic [15:0] led;

  int errors = 0;
  int checks = 0;
  logic [15:0] m_cyc;

  ram_bus_responder dut (
    .wire_clock       (clk),
    .wire_reset_n     (reset_n),
    .bus_RAM_ADDRESS  (addr),
    .wire_RW          (rw),
    .bus_RAM_DATA_IN  (din),
    .bus_RAM_DATA_OUT (dout),
    .wire_ready       (ready),
    .bus_LED          (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference cycle counter.
  always @(posedge clk) begin
    if (!reset_n) m_cyc <= 16'd0;
    else          m_cyc <= m_cyc + 16'd1;
  end

  typedef struct {
    logic [15:0] addr;
    logic        rw;
    logic [15:0] din;
    logic [15:0] pre;
    logic [15:0] post;
    logic [15:0] led;
  } vec_t;

  vec_t vecs[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sweep(input string name);
    int bad;
    bad = 0;
    for (int i = 1; i <= 1024; i++) begin
      tick();
      if (i < 1024 && (ready !== 1'b0 || dout !== 16'h0000)) bad++;
    end
    chk({name, "_early"}, 16'(bad), 16'd0);
    chk({name, "_ready"}, {15'd0, ready}, 16'd1);
  endtask

  logic [15:0] c_start;

  initial begin
    vecs[0]  = '{16'h0005, 1'b1, 16'h1234, 16'h0000, 16'h1234, 16'h0000};
    vecs[1]  = '{16'h0005, 1'b0, 16'h0000, 16'h1234, 16'h1234, 16'h0000};
    vecs[2]  = '{16'hFF02, 1'b0, 16'h0000, 16'h0001, 16'h0001, 16'h0000};
    vecs[3]  = '{16'h0010, 1'b1, 16'hAAAA, 16'h0000, 16'hAAAA, 16'h0000};
    vecs[4]  = '{16'h0010, 1'b1, 16'h5555, 16'hAAAA, 16'h5555, 16'h0000};
    vecs[5]  = '{16'hFF00, 1'b1, 16'h00FF, 16'h0000, 16'h00FF, 16'h00FF};
    vecs[6]  = '{16'hFF02, 1'b0, 16'h0000, 16'h0003, 16'h0003, 16'h00FF};
    vecs[7]  = '{16'h03FF, 1'b1, 16'hABCD, 16'h0000, 16'hABCD, 16'h00FF};
    vecs[8]  = '{16'h0400, 1'b1, 16'h9999, 16'h0000, 16'h0000, 16'h00FF};
    vecs[9]  = '{16'hFF03, 1'b1, 16'h7777, 16'h0000, 16'h0000, 16'h00FF};
    vecs[10] = '{16'h8000, 1'b1, 16'h6666, 16'h0000, 16'h0000, 16'h00FF};
    vecs[11] = '{16'hFF02, 1'b0, 16'h0000, 16'h0004, 16'h0004, 16'h00FF};
    vecs[12] = '{16'h0005, 1'b0, 16'h0000, 16'h1234, 16'h1234, 16'h00FF};

    reset_n = 1'b0;
    addr    = 16'h0000;
    rw      = 1'b1;
    din     = 16'hBEEF;
    tick();
    chk("rst_ready", {15'd0, ready}, 16'd0);
    chk("rst_led", led, 16'h0000);
    tick();
    tick();
    chk("rst_dout", dout, 16'h0000);

    // Release with a write pending on address 0; the sweep must ignore it.
    reset_n = 1'b1;
    sweep("sweep1");
    rw = 1'b0;
    #1;
    chk("mem0_after_sweep", dout, 16'h0000);
    addr = 16'hFF01;
    #1;
    chk("cyc_after_sweep", dout, 16'd1024);

    for (int i = 0; i < 13; i++) begin
      addr = vecs[i].addr;
      rw   = vecs[i].rw;
      din  = vecs[i].din;
      #1;
      chk($sformatf("vec%0d_pre", i), dout, vecs[i].pre);
      tick();
      chk($sformatf("vec%0d_post", i), dout, vecs[i].post);
      chk($sformatf("vec%0d_led", i), led, vecs[i].led);
    end
    rw = 1'b0;

    // Writing the cycle counter is dropped; it keeps counting.
    addr = 16'hFF01;
    rw   = 1'b1;
    din  = 16'h1111;
    #1;
    chk("cyc_pre_write", dout, m_cyc);
    tick();
    rw = 1'b0;
    chk("cyc_post_write", dout, m_cyc);
    chk("led_hold", led, 16'h00FF);

    // 65536 consecutive RAM writes: cycle counter wraps, write counter saturates.
    c_start = m_cyc;
    addr = 16'h0020;
    din  = 16'h0F0F;
    rw   = 1'b1;
    repeat (65536) tick();
    rw   = 1'b0;
    addr = 16'hFF01;
    #1;
    chk("cyc_wrap", dout, c_start);
    addr = 16'hFF02;
    #1;
    chk("wcnt_sat", dout, 16'hFFFF);
    addr = 16'h0021;
    rw   = 1'b1;
    tick();
    rw   = 1'b0;
    addr = 16'hFF02;
    #1;
    chk("wcnt_sat_hold", dout, 16'hFFFF);
    addr = 16'h0020;
    #1;
    chk("mem20", dout, 16'h0F0F);

    // Reset pulse mid-run.
    addr    = 16'h0005;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("rst2_led", led, 16'h0000);
    chk("rst2_ready", {15'd0, ready}, 16'd0);
    chk("rst2_dout", dout, 16'h0000);
    sweep("sweep2");
    chk("mem5_cleared", dout, 16'h0000);
    addr = 16'hFF02;
    #1;
    chk("wcnt_cleared", dout, 16'h0000);
    addr = 16'hFF00;
    #1;
    chk("led_read_cleared", dout, 16'h0000);
    addr = 16'hFF01;
    #1;
    chk("cyc_after_sweep2", dout, m_cyc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
